// File: rtl/uc_sched_pkg.sv
// Shared types for the unit-clause scheduler: literal format, engine count, FSM states.
package uc_sched_pkg;

    localparam int unsigned NUM_ENGINE = 4;
    localparam int unsigned VAR_MAX    = 256;
    localparam int unsigned VAR_W      = $clog2(VAR_MAX);

    typedef struct packed {
        logic             neg;
        logic [VAR_W-1:0] var_idx;
    } lit_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StArb,
        StDone,
        StConflict
    } ucs_state_t;

endpackage

// File: rtl/ucs_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above rr, wrapping around.
module ucs_rr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] rr_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] rr_next_o,
    output logic         gnt_v_o
);

    logic [W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        rr_next_o = rr_i;
        gnt_v_o   = 1'b0;
        idx       = '0;
        for (int i = 0; i < int'(N); i++) begin
            // N is a power of two, so the W-bit sum wraps naturally.
            idx = rr_i + W'(i);
            if (en_i && !gnt_v_o && req_i[idx]) begin
                gnt_v_o    = 1'b1;
                gnt_o[idx] = 1'b1;
                rr_next_o  = idx + W'(1);
            end
        end
    end

endmodule

// File: rtl/uc_sched.sv
// Unit-clause scheduler: loads memory unit clauses, round-robins engine implications,
// filters them through an assignment scoreboard and broadcasts new literals.
module uc_sched
    import uc_sched_pkg::*;
#(
    parameter int unsigned NUM_ENGINE = uc_sched_pkg::NUM_ENGINE,
    parameter int unsigned VAR_MAX    = uc_sched_pkg::VAR_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mem2ucs_valid,
    input  lit_t                  mem2ucs_lit,
    input  logic                  mem2ucs_done,
    output logic                  mem2ucs_ready,
    input  logic [NUM_ENGINE-1:0] eng2ucs_valid,
    input  lit_t [NUM_ENGINE-1:0] eng2ucs_lit,
    input  logic [NUM_ENGINE-1:0] eng2ucs_busy,
    output logic [NUM_ENGINE-1:0] ucs2eng_pop,
    input  logic [NUM_ENGINE:0]   eng2ucs_full,
    output logic                  ucs2eng_push,
    output lit_t                  ucs2eng_lit,
    output logic                  conflict,
    output lit_t                  conflict_lit,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned RrW = $clog2(NUM_ENGINE);

    ucs_state_t           state_q, state_d;
    logic [RrW-1:0]       rr_q, rr_d;
    logic                 pend_v_q, pend_v_d;
    lit_t                 pend_lit_q, pend_lit_d;
    logic [VAR_MAX-1:0]   assigned_q, assigned_d;
    logic [VAR_MAX-1:0]   value_q, value_d;
    logic                 conflict_q, conflict_d;
    lit_t                 conflict_lit_q, conflict_lit_d;
    logic                 done_q, done_d;

    logic                 chk_en;
    logic [VAR_W-1:0]     pv;
    logic                 null_lit;
    logic                 sb_hit;
    logic                 sb_same;
    logic                 push;
    logic                 drop;
    logic                 conf_det;
    logic                 pend_leaving;
    logic                 can_load;
    logic                 arb_en;
    logic [NUM_ENGINE-1:0] gnt;
    logic [RrW-1:0]       rr_next;
    logic                 gnt_v;
    lit_t                 eng_sel;

    // Pend is only checked while a round is running; start wins over everything.
    assign chk_en   = pend_v_q && (state_q == StLoad || state_q == StArb) && !start;
    assign pv       = pend_lit_q.var_idx;
    assign null_lit = (pv == '0);
    assign sb_hit   = assigned_q[pv];
    assign sb_same  = (value_q[pv] != pend_lit_q.neg);

    assign push         = chk_en && !null_lit && !sb_hit && !(|eng2ucs_full);
    assign drop         = chk_en && (null_lit || (sb_hit && sb_same));
    assign conf_det     = chk_en && !null_lit && sb_hit && !sb_same;
    assign pend_leaving = drop || push || conf_det;

    // A detected conflict discards pend, so nothing new is accepted that cycle.
    assign can_load = (!pend_v_q || pend_leaving) && !conf_det && !start;
    assign arb_en   = (state_q == StArb) && can_load;

    ucs_rr_arbiter #(
        .N (NUM_ENGINE),
        .W (RrW)
    ) u_arb (
        .req_i     (eng2ucs_valid),
        .rr_i      (rr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .rr_next_o (rr_next),
        .gnt_v_o   (gnt_v)
    );

    always_comb begin
        eng_sel = '0;
        for (int i = 0; i < int'(NUM_ENGINE); i++) begin
            if (gnt[i]) begin
                eng_sel = eng2ucs_lit[i];
            end
        end
    end

    assign mem2ucs_ready = (state_q == StLoad) && can_load;
    assign ucs2eng_pop   = gnt;
    assign ucs2eng_push  = push;
    assign ucs2eng_lit   = push ? pend_lit_q : '0;
    assign conflict      = conflict_q;
    assign conflict_lit  = conflict_lit_q;
    assign done          = done_q;
    assign busy          = (state_q == StLoad) || (state_q == StArb);

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        pend_v_d       = pend_v_q && !pend_leaving;
        pend_lit_d     = pend_lit_q;
        assigned_d     = assigned_q;
        value_d        = value_q;
        conflict_d     = conflict_q;
        conflict_lit_d = conflict_lit_q;
        done_d         = done_q;

        if (start) begin
            state_d        = StLoad;
            rr_d           = '0;
            pend_v_d       = 1'b0;
            pend_lit_d     = '0;
            assigned_d     = '0;
            value_d        = '0;
            conflict_d     = 1'b0;
            conflict_lit_d = '0;
            done_d         = 1'b0;
        end else begin
            if (push) begin
                assigned_d[pv] = 1'b1;
                value_d[pv]    = !pend_lit_q.neg;
            end
            if (mem2ucs_ready && mem2ucs_valid) begin
                pend_v_d   = 1'b1;
                pend_lit_d = mem2ucs_lit;
            end
            if (gnt_v) begin
                pend_v_d   = 1'b1;
                pend_lit_d = eng_sel;
                rr_d       = rr_next;
            end

            case (state_q)
                StLoad: begin
                    if (mem2ucs_done && !pend_v_q) begin
                        state_d = StArb;
                    end
                end
                StArb: begin
                    if (!pend_v_q && eng2ucs_valid == '0 && eng2ucs_busy == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase

            if (conf_det) begin
                state_d        = StConflict;
                conflict_d     = 1'b1;
                conflict_lit_d = pend_lit_q;
                pend_v_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            rr_q           <= '0;
            pend_v_q       <= 1'b0;
            pend_lit_q     <= '0;
            assigned_q     <= '0;
            value_q        <= '0;
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            pend_v_q       <= pend_v_d;
            pend_lit_q     <= pend_lit_d;
            assigned_q     <= assigned_d;
            value_q        <= value_d;
            conflict_q     <= conflict_d;
            conflict_lit_q <= conflict_lit_d;
            done_q         <= done_d;
        end
    end

endmodule
